// File: rtl/adc_pkt_builder.sv
// adc_pkt_builder: captures one ADC channel per strobe into a sample FIFO and frames it as header+payload packets on a valid/ready stream
module adc_pkt_builder #(
  parameter int NUM_CH = 9,
  parameter int CH_W = 96,
  parameter int OUT_W = 32,
  parameter int SMP_PER_PKT = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_en,
  input  logic                   cfg_mode,
  input  logic [CW-1:0]          cfg_ch_sel,
  input  logic [NUM_CH*CH_W-1:0] data_in,
  input  logic                   data_vld,
  output logic [OUT_W-1:0]       pkt_data,
  output logic                   pkt_vld,
  input  logic                   pkt_rdy,
  output logic                   pkt_sop,
  output logic                   pkt_eop,
  output logic [15:0]            ovf_cnt,
  output logic                   busy
);
  localparam int WPS = CH_W / OUT_W;
  localparam int WW = WPS > 1 ? $clog2(WPS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] SPP = 8'(SMP_PER_PKT);
  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
  state_t state, state_n;
  logic [CW+CH_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic [CW-1:0] sp, ch, head_ch;
  logic [CH_W-1:0] head;
  logic [7:0] seq, s;
  logic [WW-1:0] w;
  logic empty, full, cap, push, pop, hs, last_w;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign cap = cfg_en && data_vld;
  assign ch = cfg_mode ? sp : ({1'b0, cfg_ch_sel} < (CW+1)'(NUM_CH) ? cfg_ch_sel : '0);
  assign push = cap && !full;
  assign {head_ch, head} = mem[rp[AW-1:0]];
  assign hs = pkt_vld && pkt_rdy;
  assign last_w = w == WW'(WPS-1);
  // in flush the FIFO is empty, so padding words advance w/s without popping
  assign pop = state == PAY && hs && last_w && !empty;
  assign busy = state != IDLE || !empty;
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= {ch, data_in[ch*CH_W +: CH_W]};
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      ovf_cnt <= '0;
      sp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (cap && full && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
      sp <= (!cfg_en || !cfg_mode) ? '0 : cap ? (sp == CW'(NUM_CH-1) ? '0 : sp + 1'b1) : sp;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      seq <= '0;
      s <= '0;
      w <= '0;
    end else begin
      state <= state_n;
      if (state == PAY && hs) begin
        w <= last_w ? '0 : w + 1'b1;
        if (last_w) s <= pkt_eop ? '0 : s + 1'b1;
        if (pkt_eop) seq <= seq + 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    pkt_vld = 1'b0;
    pkt_sop = 1'b0;
    pkt_eop = 1'b0;
    pkt_data = '0;
    case (state)
      IDLE: state_n = empty ? IDLE : HDR;
      HDR: begin
        pkt_vld = 1'b1;
        pkt_sop = 1'b1;
        pkt_data = OUT_W'({8'hA5, seq, 8'(head_ch), SPP});
        state_n = pkt_rdy ? PAY : HDR;
      end
      PAY: begin
        pkt_vld = !empty || !cfg_en;
        pkt_data = empty ? '0 : head[(WPS-1-w)*OUT_W +: OUT_W];
        pkt_eop = pkt_vld && last_w && s == SPP - 8'd1;
        state_n = (hs && pkt_eop) ? IDLE : PAY;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_adc_pkt_builder.sv
// tb_adc_pkt_builder: directed self-checking bench for adc_pkt_builder with two-sample packets
module tb_adc_pkt_builder;
  localparam int NUM_CH = 9;
  localparam int CH_W = 96;
  logic clk = 1'b0, rst = 1'b1, cfg_en = 1'b0, cfg_mode = 1'b0, data_vld = 1'b0, pkt_rdy = 1'b1;
  logic [3:0] cfg_ch_sel = '0;
  logic [NUM_CH*CH_W-1:0] data_in = '0;
  logic [31:0] pkt_data;
  logic pkt_vld, pkt_sop, pkt_eop, busy;
  logic [15:0] ovf_cnt;
  int cmps = 0, errs = 0;
  always #5 clk = ~clk;
  adc_pkt_builder #(.NUM_CH(NUM_CH), .CH_W(CH_W), .OUT_W(32), .SMP_PER_PKT(2), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_ch_sel(cfg_ch_sel),
    .data_in(data_in), .data_vld(data_vld), .pkt_data(pkt_data), .pkt_vld(pkt_vld),
    .pkt_rdy(pkt_rdy), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop), .ovf_cnt(ovf_cnt), .busy(busy)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // word w of channel c under pattern p; w=0 is the MSB word
  function automatic logic [31:0] wd(input int p, input int c, input int w);
    return {8'(p), 8'(c), 16'(w)};
  endfunction
  function automatic logic [31:0] hdr(input int sq, input int c);
    return {8'hA5, 8'(sq), 8'(c), 8'h02};
  endfunction
  task automatic strobe(input int p);
    for (int c = 0; c < NUM_CH; c++) data_in[c*CH_W +: CH_W] = {wd(p, c, 0), wd(p, c, 1), wd(p, c, 2)};
    data_vld = 1'b1;
    tick();
    data_vld = 1'b0;
  endtask
  task automatic expect_word(input string tag, input logic [31:0] d, input logic sop, input logic eop);
    int n = 0;
    while (!(pkt_vld && pkt_rdy) && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " wait"}, 32'(n < 40), 32'd1);
    chk(tag, pkt_data, d);
    chk({tag, " sop"}, 32'(pkt_sop), 32'(sop));
    chk({tag, " eop"}, 32'(pkt_eop), 32'(eop));
    tick();
  endtask
  task automatic expect_sample(input string tag, input int p, input int c, input logic last);
    for (int w = 0; w < 3; w++) expect_word(tag, wd(p, c, w), 1'b0, last && w == 2);
  endtask
  task automatic reset_pulse;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst vld", 32'(pkt_vld), 0);
    chk("rst sop", 32'(pkt_sop), 0);
    chk("rst eop", 32'(pkt_eop), 0);
    chk("rst data", pkt_data, 0);
    chk("rst ovf", 32'(ovf_cnt), 0);
    chk("rst busy", 32'(busy), 0);
    cfg_en = 1'b1;
    cfg_ch_sel = 4'd3;
    strobe(1);
    chk("lat n1 vld", 32'(pkt_vld), 0);
    chk("lat n1 busy", 32'(busy), 1);
    strobe(2);
    chk("lat n2 vld", 32'(pkt_vld), 1);
    expect_word("fx hdr0", 32'hA5000302, 1'b1, 1'b0);
    expect_sample("fx s1", 1, 3, 1'b0);
    expect_sample("fx s2", 2, 3, 1'b1);
    strobe(3);
    expect_word("fx hdr1", 32'hA5010302, 1'b1, 1'b0);
    expect_word("fx s3w0", wd(3, 3, 0), 1'b0, 1'b0);
    reset_pulse();
    chk("mid rst vld", 32'(pkt_vld), 0);
    chk("mid rst sop", 32'(pkt_sop), 0);
    chk("mid rst eop", 32'(pkt_eop), 0);
    chk("mid rst data", pkt_data, 0);
    chk("mid rst busy", 32'(busy), 0);
    strobe(4);
    cfg_en = 1'b0;
    chk("post rst n1 vld", 32'(pkt_vld), 0);
    tick();
    chk("post rst n2 vld", 32'(pkt_vld), 1);
    expect_word("fl hdr", 32'hA5000302, 1'b1, 1'b0);
    expect_sample("fl s4", 4, 3, 1'b0);
    expect_word("fl pad0", 0, 1'b0, 1'b0);
    expect_word("fl pad1", 0, 1'b0, 1'b0);
    expect_word("fl pad2", 0, 1'b0, 1'b1);
    chk("fl busy", 32'(busy), 0);
    reset_pulse();
    cfg_en = 1'b1;
    cfg_mode = 1'b1;
    fork
      for (int i = 0; i < 10; i++) strobe(16 + i);
      for (int k = 0; k < 5; k++) begin
        expect_word("sc hdr", hdr(k, 2 * k), 1'b1, 1'b0);
        expect_sample("sc a", 16 + 2 * k, 2 * k, 1'b0);
        expect_sample("sc b", 17 + 2 * k, (2 * k + 1) % NUM_CH, 1'b1);
      end
    join
    chk("sc ovf", 32'(ovf_cnt), 0);
    reset_pulse();
    cfg_mode = 1'b0;
    cfg_ch_sel = 4'd5;
    pkt_rdy = 1'b0;
    for (int i = 0; i < 12; i++) strobe(32 + i);
    chk("ov cnt", 32'(ovf_cnt), 4);
    chk("ov busy", 32'(busy), 1);
    chk("ov hold vld", 32'(pkt_vld), 1);
    chk("ov hold hdr", pkt_data, hdr(0, 5));
    pkt_rdy = 1'b1;
    expect_word("ov hdr0", hdr(0, 5), 1'b1, 1'b0);
    expect_word("ov w0", wd(32, 5, 0), 1'b0, 1'b0);
    expect_word("ov w1", wd(32, 5, 1), 1'b0, 1'b0);
    pkt_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp vld", 32'(pkt_vld), 1);
      chk("bp data", pkt_data, wd(32, 5, 2));
      tick();
    end
    pkt_rdy = 1'b1;
    expect_word("ov w2", wd(32, 5, 2), 1'b0, 1'b0);
    expect_sample("ov s33", 33, 5, 1'b1);
    for (int k = 1; k < 4; k++) begin
      expect_word("ov hdr", hdr(k, 5), 1'b1, 1'b0);
      expect_sample("ov a", 32 + 2 * k, 5, 1'b0);
      expect_sample("ov b", 33 + 2 * k, 5, 1'b1);
    end
    chk("ov done busy", 32'(busy), 0);
    chk("ov cnt kept", 32'(ovf_cnt), 4);
    cfg_ch_sel = 4'd12;
    strobe(50);
    strobe(51);
    expect_word("oor hdr", hdr(4, 0), 1'b1, 1'b0);
    expect_sample("oor a", 50, 0, 1'b0);
    expect_sample("oor b", 51, 0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
